isqrt_rr_arbiter: RTL and testbench
===================================

Name: isqrt_rr_arbiter

Overview:
- Shares one pipelined isqrt instance between N_REQ independent requesters (e.g. several formula FSMs).
- Round-robin arbitration, one issue per cycle; an in-order tag FIFO routes each result back to the requester that issued it.
- Sits between the formula FSMs' isqrt_x/isqrt_y ports and a single isqrt instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 8, tag FIFO depth = maximum requests in flight inside isqrt (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_vld  in  N_REQ  request valid per requester.
- req_x  in  N_REQ*32  packed operands; requester i uses bits [32*i+31:32*i].
- req_rdy  out  N_REQ  grant; combinational, one-hot or zero.
- rsp_vld  out  N_REQ  result valid per requester; registered, one-hot or zero.
- rsp_y  out  16  result value, shared by all requesters.
- isqrt_x_vld  out  1  issue strobe to isqrt.
- isqrt_x  out  32  operand to isqrt.
- isqrt_y_vld  in  1  isqrt result strobe.
- isqrt_y  in  16  isqrt result.

Behaviour:
- Reset (rst==0 at posedge): rr pointer=0, tag FIFO empty (wr_ptr=rd_ptr=count=0), rsp_vld=0, rsp_y=0.
- Issue allowed when count<MAX_OUTSTANDING, or count==MAX_OUTSTANDING and isqrt_y_vld=1 in the same cycle (pop frees a slot).
- Arbitration, combinational: scan requesters starting at rr pointer, wrapping modulo N_REQ. The first i with req_vld[i]=1 wins: req_rdy[i]=1, isqrt_x_vld=1, isqrt_x=req_x[i].
- No winner or issue blocked: req_rdy=0, isqrt_x_vld=0, isqrt_x=0.
- Handshake: a transfer occurs when req_vld[i]&req_rdy[i]. Requester holds req_vld/req_x until granted. req_vld may drop without a grant.
- On grant i: rr pointer <= (i+1) mod N_REQ; push i into tag FIFO. Pointer is unchanged when there is no grant.
- isqrt contract: results return in issue order, any latency >=1, no backpressure.
- On isqrt_y_vld with count>0: pop tag t. Next cycle rsp_vld[t]=1 and rsp_y=isqrt_y, so response latency is 1 cycle after isqrt_y_vld. Otherwise rsp_vld=0 next cycle; rsp_y holds its last value.
- Simultaneous push and pop: count unchanged, both pointers advance; the popped tag is the oldest entry, never the one being pushed.
- isqrt_y_vld with count==0 (spurious, or stale after a mid-operation reset): result dropped, no rsp_vld, state unchanged.
- Reset mid-operation: all in-flight tags discarded. Results still emerging from isqrt afterwards fall under the spurious case.
- Fairness: a requester holding req_vld continuously is granted within N_REQ issue-eligible cycles.
- Full throughput: one issue per cycle while count<MAX_OUTSTANDING.

Optional Feature:
- Macro ISQRT_ARB_ERR_EN.
- Defined: adds output err (1 bit, registered, reset 0). err is sticky: it sets on isqrt_y_vld with count==0 and clears only on reset.
- Also defined: the arbiter asserts, in simulation only, that req_x of a requester does not change while req_vld=1 and req_rdy=0.
- Undefined: no err port, no assertion; spurious results are silently dropped.

Test Plan:
- Single request: req_vld=4'b0100, req_x[2]=144, isqrt model latency 3 -> req_rdy=4'b0100 same cycle, isqrt_x=144; rsp_vld=4'b0100 with rsp_y=12 on cycle 4 after grant.
- Round-robin: all four req_vld held high, operands 1,4,9,16 -> grants in order 0,1,2,3,0.... After rr pointer reaches 2, requests {0,3} grant 3 before 0.
- Full FIFO: model latency 20, continuous requests from requester 1 -> exactly 8 grants, then req_rdy=0 until the first isqrt_y_vld. In that cycle a 9th grant coincides with the pop, and count stays 8.
- Routing under interleave: issue 0:x=100, 3:x=49, 0:x=25 back-to-back -> rsp_vld sequence 0(y=10), 3(y=7), 0(y=5), in order.
- Reset mid-operation: 3 requests in flight, pull rst low 1 cycle -> rsp_vld stays 0 for the 3 stale results. With ISQRT_ARB_ERR_EN err rises 1 cycle after the first stale isqrt_y_vld and stays 1.
- Idle: no req_vld for 10 cycles -> isqrt_x_vld=0, req_rdy=0, rsp_vld=0, rr pointer unchanged.

Source files
------------

// File: rtl/isqrt_rr_arbiter_if.sv
// Bundle between the formula FSMs, the isqrt arbiter and the shared isqrt unit.
//   slave  : the arbiter's view (takes requests and isqrt results, drives grants,
//            responses and the isqrt issue port)
//   master : the opposite side (requesters plus isqrt unit)
// Signals:
//   req_vld/req_x   per-requester valid and packed 32-bit operands
//   req_rdy         per-requester grant
//   rsp_vld/rsp_y   per-requester result valid, shared 16-bit result
//   isqrt_x_vld/x   issue strobe and operand towards isqrt
//   isqrt_y_vld/y   result strobe and value from isqrt
interface isqrt_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_vld;
  logic [32*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    rsp_vld;
  logic [15:0]         rsp_y;
  logic                isqrt_x_vld;
  logic [31:0]         isqrt_x;
  logic                isqrt_y_vld;
  logic [15:0]         isqrt_y;

  modport slave (
    input  req_vld, req_x, isqrt_y_vld, isqrt_y,
    output req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x
  );

  modport master (
    output req_vld, req_x, isqrt_y_vld, isqrt_y,
    input  req_rdy, rsp_vld, rsp_y, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined isqrt unit between N_REQ requesters.
// One request is issued per cycle; an in-order tag FIFO remembers which
// requester issued each operation so the result is routed back to it.
// Ports:
//   clk   clock
//   rst   synchronous active-low reset
//   bus   isqrt_rr_arbiter_if.slave (requests, grants, responses, isqrt port)
//   err   (only with ISQRT_ARB_ERR_EN) sticky flag: isqrt result with nothing
//         outstanding
// Optional feature macro: ISQRT_ARB_ERR_EN (adds err and an operand-hold check).
module isqrt_rr_arbiter #(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  isqrt_rr_arbiter_if.slave   bus
`ifdef ISQRT_ARB_ERR_EN
  ,
  output logic                err
`endif
);
  localparam int TW = $clog2(N_REQ);
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_OUTSTANDING);

  typedef logic [TW-1:0] tag_t;

  tag_t              ptr_q, ptr_d;
  tag_t              tag_mem_q [MAX_OUTSTANDING];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [N_REQ-1:0]  rsp_vld_q;
  logic [15:0]       rsp_y_q;
  logic [31:0]       op_s [N_REQ];
  logic              found_s, grant_s, pop_s, can_issue_s;
  tag_t              win_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_op
    assign op_s[g] = bus.req_x[32*g +: 32];
  end

  // Arbitration, issue eligibility and next-state for pointer and count.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    // Scan from the rr pointer; the first valid requester found wins.
    for (int k = 0; k < N_REQ; k++) begin
      tag_t idx;
      logic hit;
      idx     = tag_t'((int'(ptr_q) + k) % N_REQ);
      hit     = bus.req_vld[idx] && !found_s;
      win_s   = hit ? idx : win_s;
      found_s = found_s | hit;
    end
    pop_s = bus.isqrt_y_vld && (count_q != '0);
    // When full, a pop in the same cycle frees the slot the push needs.
    can_issue_s = (count_q < MAX_CNT) || pop_s;
    grant_s     = found_s && can_issue_s;
    if (grant_s) begin
      ptr_d = (win_s == tag_t'(N_REQ-1)) ? '0 : win_s + tag_t'(1);
    end else begin
      ptr_d = ptr_q;
    end
    case ({grant_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  assign bus.req_rdy     = grant_s ? (N_REQ'(1'b1) << win_s) : '0;
  assign bus.isqrt_x_vld = grant_s;
  assign bus.isqrt_x     = grant_s ? op_s[win_s] : 32'd0;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_y       = rsp_y_q;

  // Control state: rr pointer, FIFO pointers/count and the response register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rsp_vld_q <= '0;
      rsp_y_q   <= 16'd0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (grant_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        // The read uses the pre-edge contents, so a same-cycle push into a
        // full FIFO (wr_ptr == rd_ptr) never shadows the oldest tag.
        rsp_vld_q <= N_REQ'(1'b1) << tag_mem_q[rd_ptr_q];
        rsp_y_q   <= bus.isqrt_y;
      end else begin
        rsp_vld_q <= '0;
      end
    end
  end

  // Tag storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      tag_mem_q[wr_ptr_q] <= win_s;
    end
  end

`ifdef ISQRT_ARB_ERR_EN
  logic err_q;

  // Sticky flag for an isqrt result arriving with no outstanding tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (bus.isqrt_y_vld && (count_q == '0));
    end
  end

  assign err = err_q;

`ifndef SYNTHESIS
  for (genvar g = 0; g < N_REQ; g++) begin : g_hold
    a_hold_x: assert property (@(posedge clk) disable iff (!rst)
      (bus.req_vld[g] && !bus.req_rdy[g]) |=>
        (!bus.req_vld[g] || $stable(bus.req_x[32*g +: 32])));
  end
`endif
`endif
endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
module tb_isqrt_rr_arbiter;
  localparam int N   = 4;
  localparam int MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef ISQRT_ARB_ERR_EN
  logic err;
`endif

  isqrt_rr_arbiter_if #(.N_REQ(N)) bus ();

  isqrt_rr_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ISQRT_ARB_ERR_EN
    ,
    .err (err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = 16'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ((32'(t) * 32'(t)) <= x) r = t;
    end
    return r;
  endfunction

  // ---------------- isqrt unit model (fixed latency, in order) ----------------
  typedef struct { int due; logic [15:0] y; } pe_t;
  pe_t pipe[$];
  int  lat = 3;
  int  cyc = 0;
  logic        smp_v;
  logic [31:0] smp_x;

  initial begin
    bus.isqrt_y_vld = 1'b0;
    bus.isqrt_y     = 16'd0;
    bus.req_vld     = '0;
    bus.req_x       = '0;
  end

  always @(posedge clk) begin
    if (smp_v === 1'b1) pipe.push_back('{due: cyc + lat, y: isqrt32(smp_x)});
    cyc = cyc + 1;
    #1;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      bus.isqrt_y_vld = 1'b1;
      bus.isqrt_y     = pipe[0].y;
      void'(pipe.pop_front());
    end else begin
      bus.isqrt_y_vld = 1'b0;
      bus.isqrt_y     = 16'hdead;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct { int req; logic [15:0] y; } sb_t;
  sb_t sb_q[$];
  int        ptr_m = 0;
  logic [3:0]  exp_rsp_vld = 4'd0;
  logic [15:0] exp_rsp_y   = 16'd0;
  logic        err_m = 1'b0;
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    smp_v = bus.isqrt_x_vld;
    smp_x = bus.isqrt_x;
    if (mon_en) begin
      int win;
      bit found, elig, grant, pop;
      logic [3:0] exp_rdy;
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr_m + k) % N;
        if (!found && bus.req_vld[idx]) begin found = 1'b1; win = idx; end
      end
      elig    = (sb_q.size() < MAX) || (sb_q.size() == MAX && bus.isqrt_y_vld);
      grant   = found && elig;
      exp_rdy = grant ? (4'd1 << win) : 4'd0;
      chk("mon_req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
      chk("mon_x_vld", 32'(bus.isqrt_x_vld), 32'(grant));
      chk("mon_x", bus.isqrt_x, grant ? bus.req_x[32*win +: 32] : 32'd0);
      chk("mon_rsp_vld", 32'(bus.rsp_vld), 32'(exp_rsp_vld));
      if (exp_rsp_vld != 4'd0) chk("mon_rsp_y", 32'(bus.rsp_y), 32'(exp_rsp_y));
`ifdef ISQRT_ARB_ERR_EN
      chk("mon_err", 32'(err), 32'(err_m));
`endif
      if (!rst) begin
        sb_q.delete();
        ptr_m       = 0;
        exp_rsp_vld = 4'd0;
        exp_rsp_y   = 16'd0;
        err_m       = 1'b0;
      end else begin
        pop = bus.isqrt_y_vld && (sb_q.size() > 0);
        if (bus.isqrt_y_vld && sb_q.size() == 0) err_m = 1'b1;
        if (pop) begin
          sb_t e;
          e = sb_q.pop_front();
          exp_rsp_vld = 4'd1 << e.req;
          exp_rsp_y   = e.y;
        end else begin
          exp_rsp_vld = 4'd0;
        end
        if (grant) begin
          sb_q.push_back('{req: win, y: isqrt32(bus.req_x[32*win +: 32])});
          ptr_m = (win + 1) % N;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [3:0] v, input logic [127:0] x);
    @(posedge clk); #1;
    bus.req_vld = v;
    bus.req_x   = x;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_vld = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (sb_q.size() != 0 || pipe.size() != 0); k++) @(negedge clk);
    chk("drain", 32'(sb_q.size() + pipe.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] xall;
    logic [3:0]   rr_v [8];
    logic [3:0]   rr_e [8];
    logic [31:0]  x1;

    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
`ifdef ISQRT_ARB_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif

    // single request, latency 3
    lat = 3;
    x = '0;
    x[95:64] = 32'd144;
    drive(4'b0100, x);
    @(negedge clk);
    chk("single_rdy", 32'(bus.req_rdy), 32'h4);
    chk("single_x", bus.isqrt_x, 32'd144);
    drive(4'b0000, x);
    repeat (4) @(negedge clk);
    chk("single_rsp_vld", 32'(bus.rsp_vld), 32'h4);
    chk("single_rsp_y", 32'(bus.rsp_y), 32'd12);
    drain();

    // round robin
    pulse_reset();
    xall = {32'd16, 32'd9, 32'd4, 32'd1};
    rr_v = '{4'b1111, 4'b1111, 4'b1001, 4'b1001, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    rr_e = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int j = 0; j < 8; j++) begin
      drive(rr_v[j], xall);
      @(negedge clk);
      chk($sformatf("rr_grant%0d", j), 32'(bus.req_rdy), 32'(rr_e[j]));
    end
    drive(4'b0000, xall);
    drain();

    // full FIFO, latency 20
    lat = 20;
    x1 = 32'd1000;
    for (int k = 0; k < 23; k++) begin
      x = '0;
      x[63:32] = x1;
      drive(4'b0010, x);
      @(negedge clk);
      chk($sformatf("full_grant%0d", k), 32'(bus.req_rdy), (k < 8 || k >= 20) ? 32'h2 : 32'h0);
      if (k < 8 || k >= 20) x1 = x1 + 32'd337;
    end
    drive(4'b0000, x);
    drain();

    // routing under interleave
    lat = 3;
    pulse_reset();
    x = '0; x[31:0] = 32'd100;
    drive(4'b0001, x);
    @(negedge clk);
    chk("il_g0", 32'(bus.req_rdy), 32'h1);
    x = '0; x[31:0] = 32'd25; x[127:96] = 32'd49;
    drive(4'b1001, x);
    @(negedge clk);
    chk("il_g1", 32'(bus.req_rdy), 32'h8);
    drive(4'b0001, x);
    @(negedge clk);
    chk("il_g2", 32'(bus.req_rdy), 32'h1);
    drive(4'b0000, x);
    repeat (2) @(negedge clk);
    chk("il_r0_vld", 32'(bus.rsp_vld), 32'h1);
    chk("il_r0_y", 32'(bus.rsp_y), 32'd10);
    @(negedge clk);
    chk("il_r1_vld", 32'(bus.rsp_vld), 32'h8);
    chk("il_r1_y", 32'(bus.rsp_y), 32'd7);
    @(negedge clk);
    chk("il_r2_vld", 32'(bus.rsp_vld), 32'h1);
    chk("il_r2_y", 32'(bus.rsp_y), 32'd5);
    drain();

    // reset with three requests in flight
    lat = 5;
    x = '0; x[63:32] = 32'd64;
    repeat (3) drive(4'b0010, x);
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("stale_rsp%0d", k), 32'(bus.rsp_vld), 32'd0);
    end
`ifdef ISQRT_ARB_ERR_EN
    chk("stale_err", 32'(err), 32'd1);
`endif
    drain();
    pulse_reset();
    @(negedge clk);
`ifdef ISQRT_ARB_ERR_EN
    chk("err_clr", 32'(err), 32'd0);
`endif

    // idle: pointer must survive 10 empty cycles
    x = '0; x[63:32] = 32'd9;
    drive(4'b0010, x);
    @(negedge clk);
    chk("idle_pre", 32'(bus.req_rdy), 32'h2);
    drive(4'b0000, x);
    drain();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_rdy", 32'(bus.req_rdy), 32'd0);
      chk("idle_xv", 32'(bus.isqrt_x_vld), 32'd0);
      chk("idle_rsp", 32'(bus.rsp_vld), 32'd0);
    end
    drive(4'b1111, xall);
    @(negedge clk);
    chk("idle_ptr", 32'(bus.req_rdy), 32'h4);
    drive(4'b0000, xall);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
